// File: rtl/servo_pwm_gen_if.sv
// Servo PWM generator signal bundle: command/strobe inputs and frame outputs.
interface servo_pwm_gen_if;
  logic       clk_en;
  logic       enable;
  logic [7:0] duty_in;
  logic       duty_valid;
  logic       pwm_out;
  logic       period_start;
  logic [7:0] duty_applied;
  logic       wd_timeout;

  modport master (
    output clk_en, enable, duty_in, duty_valid,
    input  pwm_out, period_start, duty_applied, wd_timeout
  );

  modport slave (
    input  clk_en, enable, duty_in, duty_valid,
    output pwm_out, period_start, duty_applied, wd_timeout
  );
endinterface

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: framed pulse output with clamped, slew-limited pulse
// width and a command watchdog that falls back to the neutral width.
module servo_pwm_gen #(
  parameter int unsigned PERIOD_TICKS = 2000,
  parameter int unsigned DUTY_MIN     = 100,
  parameter int unsigned DUTY_MAX     = 200,
  parameter int unsigned DUTY_NEUTRAL = 150,
  parameter int unsigned MAX_STEP     = 4,
  parameter int unsigned WD_PERIODS   = 10
) (
  input logic           clk,
  input logic           reset_n,
  servo_pwm_gen_if.slave bus
);

  localparam int unsigned CW = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
  localparam int unsigned WW = $clog2(WD_PERIODS + 1);

  localparam logic [CW-1:0] LAST_COUNT = CW'(PERIOD_TICKS - 1);
  localparam logic [7:0]    MIN8       = 8'(DUTY_MIN);
  localparam logic [7:0]    MAX8       = 8'(DUTY_MAX);
  localparam logic [7:0]    NEUTRAL8   = 8'(DUTY_NEUTRAL);
  localparam logic [8:0]    STEP9      = 9'(MAX_STEP);
  localparam logic [7:0]    STEP8      = 8'(MAX_STEP);
  localparam logic [WW-1:0] WD_MAX     = WW'(WD_PERIODS);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          pwm_q, pwm_d;
  logic          pstart_q, pstart_d;
  logic [7:0]    applied_q, applied_d;
  logic [7:0]    target_q, target_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          wdto_q, wdto_d;

  logic [7:0]    clamped;
  logic          boundary;
  logic [WW-1:0] wd_inc;
  logic [8:0]    tgt9, app9, diff9;
  logic [7:0]    step8;

  // Clamp the incoming command into [DUTY_MIN, DUTY_MAX] (unsigned 8-bit compare).
  always_comb begin
    clamped = bus.duty_in;
    if (bus.duty_in < MIN8)      clamped = MIN8;
    else if (bus.duty_in > MAX8) clamped = MAX8;
  end

  // Next-state, frame counter, watchdog and slew-limited pulse width.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    applied_d = applied_q;
    target_d  = target_q;
    wd_d      = wd_q;
    wdto_d    = wdto_q;
    pstart_d  = 1'b0;
    boundary  = 1'b0;
    wd_inc    = wd_q + WW'(1);
    tgt9      = '0;
    app9      = '0;
    diff9     = '0;
    step8     = '0;

    unique case (state_q)
      IDLE: begin
        count_d   = '0;
        applied_d = NEUTRAL8;
        target_d  = NEUTRAL8;
        wd_d      = '0;
        wdto_d    = 1'b0;
        if (bus.enable) begin
          state_d  = RUN;
          pstart_d = 1'b1;
        end
      end

      RUN: begin
        if (!bus.enable) begin
          state_d   = IDLE;
          count_d   = '0;
          applied_d = NEUTRAL8;
          target_d  = NEUTRAL8;
          wd_d      = '0;
          wdto_d    = 1'b0;
        end else begin
          if (bus.clk_en) begin
            if (count_q == LAST_COUNT) begin
              count_d  = '0;
              boundary = 1'b1;
            end else begin
              count_d = count_q + CW'(1);
            end
          end

          // A command on the boundary clk is the target for that boundary's step.
          if (bus.duty_valid) begin
            target_d = clamped;
            wd_d     = '0;
            wdto_d   = 1'b0;
          end else if (boundary && (wd_q != WD_MAX)) begin
            wd_d = wd_inc;
            if (wd_inc == WD_MAX) begin
              target_d = NEUTRAL8;
              wdto_d   = 1'b1;
            end
          end

          if (boundary) begin
            pstart_d = 1'b1;
            tgt9     = {1'b0, target_d};
            app9     = {1'b0, applied_q};
            if (tgt9 > app9) begin
              diff9     = tgt9 - app9;
              step8     = (diff9 > STEP9) ? STEP8 : diff9[7:0];
              applied_d = applied_q + step8;
            end else if (tgt9 < app9) begin
              diff9     = app9 - tgt9;
              step8     = (diff9 > STEP9) ? STEP8 : diff9[7:0];
              applied_d = applied_q - step8;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase

    pwm_d = (state_d == RUN) && (32'(count_d) < 32'(applied_d));
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      pwm_q     <= 1'b0;
      pstart_q  <= 1'b0;
      applied_q <= NEUTRAL8;
      target_q  <= NEUTRAL8;
      wd_q      <= '0;
      wdto_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pwm_q     <= pwm_d;
      pstart_q  <= pstart_d;
      applied_q <= applied_d;
      target_q  <= target_d;
      wd_q      <= wd_d;
      wdto_q    <= wdto_d;
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = pstart_q;
  assign bus.duty_applied = applied_q;
  assign bus.wd_timeout   = wdto_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Bench for servo_pwm_gen: frame-level reference model feeds a scoreboard
// that is checked at every period_start, plus direct reset/disable checks.
module tb_servo_pwm_gen;

  localparam int PERIOD = 300;
  localparam int DMIN   = 100;
  localparam int DMAX   = 200;
  localparam int NEU    = 150;
  localparam int STEP   = 4;
  localparam int WD     = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  servo_pwm_gen_if bus();

  servo_pwm_gen #(
    .PERIOD_TICKS(PERIOD),
    .DUTY_MIN(DMIN),
    .DUTY_MAX(DMAX),
    .DUTY_NEUTRAL(NEU),
    .MAX_STEP(STEP),
    .WD_PERIODS(WD)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {
    int applied;
    bit to;
    bit chk;
    int prev;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   hi       = 0;

  int m_app, m_tgt, m_wd;
  bit m_to;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clampf(input int d);
    if (d < DMIN) return DMIN;
    if (d > DMAX) return DMAX;
    return d;
  endfunction

  task automatic model_reset();
    m_app = NEU; m_tgt = NEU; m_wd = 0; m_to = 1'b0;
  endtask

  task automatic model_boundary(input bit valid_now, input int din);
    int d;
    if (valid_now) begin
      m_tgt = clampf(din); m_wd = 0; m_to = 1'b0;
    end else if (m_wd < WD) begin
      m_wd++;
      if (m_wd == WD) begin
        m_tgt = NEU; m_to = 1'b1;
      end
    end
    d = m_tgt - m_app;
    if (d > STEP)  d = STEP;
    if (d < -STEP) d = -STEP;
    m_app = m_app + d;
  endtask

  // One clock: set inputs for the coming edge, return 1 time unit after it.
  task automatic cyc(input bit ce, input bit dv, input int din);
    bus.clk_en     = ce;
    bus.duty_valid = dv;
    bus.duty_in    = 8'(din);
    @(posedge clk);
    #1;
    bus.clk_en     = 1'b0;
    bus.duty_valid = 1'b0;
  endtask

  task automatic idle_gaps();
    int g;
    g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
    repeat (g) cyc(1'b0, 1'b0, $urandom_range(0, 255));
  endtask

  task automatic enter_run();
    bus.enable = 1'b1;
    q.push_back('{NEU, 1'b0, 1'b0, 0});
    cyc(1'($urandom_range(0, 1)), 1'b0, 0);
  endtask

  // One full frame; optional command at tick 'at' (PERIOD-1 is the boundary clk).
  task automatic do_frame(input bit send, input int at, input int din);
    int prev;
    prev = m_app;
    for (int t = 0; t < PERIOD; t++) begin
      idle_gaps();
      if (t == PERIOD - 1) begin
        model_boundary(send && (at == t), din);
        q.push_back('{m_app, m_to, 1'b1, prev});
        cyc(1'b1, send && (at == t), din);
      end else if (send && (at == t)) begin
        m_tgt = clampf(din); m_wd = 0; m_to = 1'b0;
        cyc(1'b1, 1'b1, din);
        check("wd_timeout_after_cmd", int'(bus.wd_timeout), int'(m_to));
      end else begin
        cyc(1'b1, 1'b0, 0);
      end
    end
  endtask

  // Run n ticks into a frame, then drop enable mid-pulse.
  task automatic abort_at(input int n);
    for (int t = 0; t < n; t++) begin
      idle_gaps();
      cyc(1'b1, 1'b0, 0);
    end
    check("pwm_before_disable", int'(bus.pwm_out), (n < m_app) ? 1 : 0);
    bus.enable = 1'b0;
    cyc(1'($urandom_range(0, 1)), 1'b0, 0);
    model_reset();
    check("disable_pwm", int'(bus.pwm_out), 0);
    check("disable_duty", int'(bus.duty_applied), NEU);
    check("disable_pstart", int'(bus.period_start), 0);
    check("disable_wdto", int'(bus.wd_timeout), 0);
    cyc(1'b1, 1'b1, 30);
    check("idle_cmd_ignored", int'(bus.duty_applied), NEU);
  endtask

  // Run n ticks into a frame, then assert reset between clock edges.
  task automatic async_reset_at(input int n);
    for (int t = 0; t < n; t++) begin
      idle_gaps();
      cyc(1'b1, 1'b0, 0);
    end
    check("pwm_before_reset", int'(bus.pwm_out), (n < m_app) ? 1 : 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_pwm", int'(bus.pwm_out), 0);
    check("async_reset_duty", int'(bus.duty_applied), NEU);
    check("async_reset_pstart", int'(bus.period_start), 0);
    check("async_reset_wdto", int'(bus.wd_timeout), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: pop an expectation on every period_start; also measure pulse length.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.period_start) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_period_start: got 1 expected 0 (t=%0t)", $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("frame_duty_applied", int'(bus.duty_applied), e.applied);
          check("frame_wd_timeout", int'(bus.wd_timeout), int'(e.to));
          if (e.chk) check("prev_pulse_ticks", hi, e.prev);
          hi = 0;
        end
      end
      if (bus.clk_en && bus.pwm_out) hi++;
    end
  end

  initial begin
    bit send;
    int at;
    bus.clk_en     = 1'b0;
    bus.enable     = 1'b1;
    bus.duty_in    = '0;
    bus.duty_valid = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("reset_pwm", int'(bus.pwm_out), 0);
    check("reset_pstart", int'(bus.period_start), 0);
    check("reset_duty", int'(bus.duty_applied), NEU);
    check("reset_wdto", int'(bus.wd_timeout), 0);
    reset_n = 1'b1;

    // Slew toward 170, then silence until the watchdog returns to neutral.
    enter_run();
    do_frame(1'b1, 37, 170);
    for (int i = 0; i < 17; i++) do_frame(1'b0, 0, 0);

    // Command during timeout clears it and sets a new target.
    do_frame(1'b1, $urandom_range(0, PERIOD - 2), 160);
    for (int i = 0; i < 3; i++) do_frame(1'b0, 0, 0);

    // Disable mid-pulse, command in IDLE, re-enable.
    abort_at(50);
    enter_run();

    // Command on the boundary clk is applied at that boundary.
    do_frame(1'b1, PERIOD - 1, 152);

    // Low clamp and slew down to DUTY_MIN.
    for (int i = 0; i < 14; i++) do_frame(1'b1, $urandom_range(0, PERIOD - 1), 20);

    // High clamp and slew upward.
    for (int i = 0; i < 10; i++) do_frame(1'b1, $urandom_range(0, PERIOD - 1), 250);

    // Asynchronous reset mid-pulse, then a fresh neutral frame.
    async_reset_at(30);
    enter_run();
    do_frame(1'b0, 0, 0);

    // Random commands.
    for (int i = 0; i < 8; i++) begin
      send = 1'($urandom_range(0, 1));
      at   = ($urandom_range(0, 3) == 0) ? PERIOD - 1 : $urandom_range(0, PERIOD - 2);
      do_frame(send, at, $urandom_range(0, 255));
    end

    repeat (4) cyc(1'b0, 1'b0, 0);
    check("scoreboard_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
